// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: operation encodings, controller
// state encoding, stack-pointer update commands and the stack-pointer reset value.
// Imported by mem_access_ctrl and stack_pointer.
package mem_stage_pkg;

    // Operation code carried on req_op from the EX/MEM register.
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_PUSH   = 3'd3,
        OP_POP    = 3'd4,
        OP_PUSH32 = 3'd5,
        OP_POP32  = 3'd6,
        OP_NOP7   = 3'd7
    } mem_op_e;

    // Access controller states. The multi-cycle operations pass through
    // WR_LO (second half of PUSH32), RD_HI (second read of POP32) and
    // RD_LAST (the cycle in which read data is returned).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_LO   = 2'd1,
        ST_RD_HI   = 2'd2,
        ST_RD_LAST = 2'd3
    } mem_state_e;

    // Stack-pointer update command for the current cycle.
    typedef enum logic [2:0] {
        SP_HOLD = 3'd0,
        SP_INC1 = 3'd1,
        SP_INC2 = 3'd2,
        SP_DEC1 = 3'd3,
        SP_DEC2 = 3'd4
    } sp_upd_e;

    // The stack starts at the top of data memory: all ones at whatever
    // address width the instance uses, so users take the low ADDR_SIZE bits.
    localparam logic [31:0] SP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with +1/+2/-1/-2 update, wrapping modulo 2**ADDR_SIZE.
// Latency: the update command takes effect on the next rising edge of clk.
// Backpressure: none; the pointer holds whenever i_upd is SP_HOLD.
// Ports:
//   clk, rst : clock and synchronous active-high reset (pointer <= top of memory)
//   i_upd    : update command for this cycle
//   o_sp     : current stack pointer
module stack_pointer
    import mem_stage_pkg::*;
#(
    parameter int ADDR_SIZE = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  sp_upd_e              i_upd,
    output logic [ADDR_SIZE-1:0] o_sp
);

    logic [ADDR_SIZE-1:0] r_sp;
    logic [ADDR_SIZE-1:0] w_sp_nxt;

    // Plain ADDR_SIZE-bit arithmetic gives the required wrap-around for free.
    always_comb begin
        w_sp_nxt = r_sp;
        case (i_upd)
            SP_INC1: w_sp_nxt = r_sp + ADDR_SIZE'(1);
            SP_INC2: w_sp_nxt = r_sp + ADDR_SIZE'(2);
            SP_DEC1: w_sp_nxt = r_sp - ADDR_SIZE'(1);
            SP_DEC2: w_sp_nxt = r_sp - ADDR_SIZE'(2);
            default: w_sp_nxt = r_sp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= SP_RESET[ADDR_SIZE-1:0];
        end else begin
            r_sp <= w_sp_nxt;
        end
    end

    assign o_sp = r_sp;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns LOAD/STORE/PUSH/POP/PUSH32/POP32 into
// single-word data memory strobes, splitting 32-bit stack ops into two accesses.
// Latency: STORE/PUSH 1 cycle, LOAD/POP/PUSH32 2 cycles, POP32 3 cycles.
// Backpressure: stall=1 freezes upstream, which holds the request inputs until
// the operation's final cycle; request inputs are only decoded in IDLE.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/op/addr/wdata : request from the EX/MEM register
//   mem_read/write/addr/wd  : data memory strobes, address, write data
//   mem_rd                : data memory read data, one cycle after mem_read
//   stall                 : hold upstream stages this cycle
//   resp_valid/resp_data  : read result for MEM/WB
//   sp                    : current stack pointer
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [2:0]             req_op,
    input  logic [ADDR_SIZE-1:0]   req_addr,
    input  logic [2*WORD_SIZE-1:0] req_wdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wd,
    input  logic [WORD_SIZE-1:0]   mem_rd,
    output logic                   stall,
    output logic                   resp_valid,
    output logic [2*WORD_SIZE-1:0] resp_data,
    output logic [ADDR_SIZE-1:0]   sp
);

    mem_state_e             r_state;
    logic                   r_is32;     // RD_LAST belongs to a POP32
    logic [WORD_SIZE-1:0]   r_lo;       // low half captured in RD_HI

    mem_op_e                w_op;
    mem_state_e             w_state_nxt;
    logic                   w_is32_nxt;
    logic                   w_latch_lo;
    sp_upd_e                w_sp_upd;
    logic [ADDR_SIZE-1:0]   w_sp;
    logic                   w_rd;
    logic                   w_wr;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic [WORD_SIZE-1:0]   w_wd;
    logic                   w_stall;
    logic                   w_resp_vld;
    logic [2*WORD_SIZE-1:0] w_resp_dat;

    assign w_op = mem_op_e'(req_op);

    stack_pointer #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_stack_pointer (
        .clk   (clk),
        .rst   (rst),
        .i_upd (w_sp_upd),
        .o_sp  (w_sp)
    );

    // Strobes, address and response are combinational from state and request
    // so that single-cycle ops complete in the cycle they are presented.
    always_comb begin
        w_state_nxt = r_state;
        w_is32_nxt  = r_is32;
        w_latch_lo  = 1'b0;
        w_sp_upd    = SP_HOLD;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_addr      = '0;
        w_wd        = '0;
        w_stall     = 1'b0;
        w_resp_vld  = 1'b0;
        w_resp_dat  = '0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (w_op)
                        OP_STORE: begin
                            w_wr   = 1'b1;
                            w_addr = req_addr;
                            w_wd   = req_wdata[WORD_SIZE-1:0];
                        end
                        OP_PUSH: begin
                            // sp points at the next free slot; stack grows down.
                            w_wr     = 1'b1;
                            w_addr   = w_sp;
                            w_wd     = req_wdata[WORD_SIZE-1:0];
                            w_sp_upd = SP_DEC1;
                        end
                        OP_LOAD: begin
                            w_rd        = 1'b1;
                            w_addr      = req_addr;
                            w_stall     = 1'b1;
                            w_is32_nxt  = 1'b0;
                            w_state_nxt = ST_RD_LAST;
                        end
                        OP_POP: begin
                            w_rd        = 1'b1;
                            w_addr      = w_sp + ADDR_SIZE'(1);
                            w_sp_upd    = SP_INC1;
                            w_stall     = 1'b1;
                            w_is32_nxt  = 1'b0;
                            w_state_nxt = ST_RD_LAST;
                        end
                        OP_PUSH32: begin
                            // High half goes to the higher address so a
                            // POP32 reads low first, then high.
                            w_wr        = 1'b1;
                            w_addr      = w_sp;
                            w_wd        = req_wdata[2*WORD_SIZE-1:WORD_SIZE];
                            w_stall     = 1'b1;
                            w_state_nxt = ST_WR_LO;
                        end
                        OP_POP32: begin
                            // sp is left alone until RD_HI so both reads use
                            // the same base.
                            w_rd        = 1'b1;
                            w_addr      = w_sp + ADDR_SIZE'(1);
                            w_stall     = 1'b1;
                            w_is32_nxt  = 1'b1;
                            w_state_nxt = ST_RD_HI;
                        end
                        default: begin
                            // NOP encodings: no access.
                        end
                    endcase
                end
            end

            ST_WR_LO: begin
                // Upstream still holds req_wdata because stall was high.
                w_wr        = 1'b1;
                w_addr      = w_sp - ADDR_SIZE'(1);
                w_wd        = req_wdata[WORD_SIZE-1:0];
                w_sp_upd    = SP_DEC2;
                w_state_nxt = ST_IDLE;
            end

            ST_RD_HI: begin
                w_latch_lo  = 1'b1;
                w_rd        = 1'b1;
                w_addr      = w_sp + ADDR_SIZE'(2);
                w_sp_upd    = SP_INC2;
                w_stall     = 1'b1;
                w_state_nxt = ST_RD_LAST;
            end

            ST_RD_LAST: begin
                w_resp_vld = 1'b1;
                if (r_is32) begin
                    w_resp_dat = {mem_rd, r_lo};
                end else begin
                    w_resp_dat = {{WORD_SIZE{1'b0}}, mem_rd};
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Reset kills any in-flight operation immediately: no strobe, stall,
        // response or pointer movement in the reset cycle itself.
        if (rst) begin
            w_rd       = 1'b0;
            w_wr       = 1'b0;
            w_stall    = 1'b0;
            w_resp_vld = 1'b0;
            w_latch_lo = 1'b0;
            w_sp_upd   = SP_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_is32  <= 1'b0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_is32  <= w_is32_nxt;
            if (w_latch_lo) begin
                r_lo <= mem_rd;
            end
        end
    end

    assign mem_read   = w_rd;
    assign mem_write  = w_wr;
    assign mem_addr   = w_addr;
    assign mem_wd     = w_wd;
    assign stall      = w_stall;
    assign resp_valid = w_resp_vld;
    assign resp_data  = w_resp_dat;
    assign sp         = w_sp;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed requests against a 2K x 16 memory model,
// expected read results queued at issue and checked by a separate monitor.
module tb_mem_access_ctrl;

    localparam int W = 16;
    localparam int A = 11;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic [2:0]     req_op;
    logic [A-1:0]   req_addr;
    logic [2*W-1:0] req_wdata;
    logic           mem_read;
    logic           mem_write;
    logic [A-1:0]   mem_addr;
    logic [W-1:0]   mem_wd;
    logic [W-1:0]   mem_rd;
    logic           stall;
    logic           resp_valid;
    logic [2*W-1:0] resp_data;
    logic [A-1:0]   sp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    logic [W-1:0] mem [0:(1<<A)-1];

    mem_access_ctrl #(
        .WORD_SIZE (W),
        .ADDR_SIZE (A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .sp         (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: synchronous write, registered read.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << A); i++) mem[i] <= '0;
            mem[0] <= 16'hBEEF;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wd;
        end
        if (mem_read) mem_rd <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest queued result.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got %h, required no response", resp_data);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("resp_data", resp_data, sb_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [A-1:0] a,
                         input logic [31:0] wd);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, required finish within 20000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, '0, '0);

        // Reset for one cycle.
        step();
        rst = 1'b0;
        #2;
        chk("reset_sp",    32'(sp), 32'h7FF);
        chk("reset_rd",    32'(mem_read), 32'd0);
        chk("reset_wr",    32'(mem_write), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_resp",  32'(resp_valid), 32'd0);

        // STORE 0x00A <- 0x1234, single cycle.
        step();
        drive(1'b1, 3'd2, 11'h00A, 32'h0000_1234);
        #2;
        chk("store_wr",    32'(mem_write), 32'd1);
        chk("store_rd",    32'(mem_read), 32'd0);
        chk("store_addr",  32'(mem_addr), 32'h00A);
        chk("store_wd",    32'(mem_wd), 32'h1234);
        chk("store_stall", 32'(stall), 32'd0);

        // LOAD 0x00A: one stall cycle then the result.
        step();
        drive(1'b1, 3'd1, 11'h00A, 32'h0);
        exp_q.push_back(32'h0000_1234);
        #2;
        chk("load_rd",    32'(mem_read), 32'd1);
        chk("load_wr",    32'(mem_write), 32'd0);
        chk("load_addr",  32'(mem_addr), 32'h00A);
        chk("load_stall", 32'(stall), 32'd1);
        step();
        #2;
        chk("load_resp_vld", 32'(resp_valid), 32'd1);
        chk("load_stall2",   32'(stall), 32'd0);
        chk("mem_00A",       32'(mem[11'h00A]), 32'h1234);

        // PUSH32 0xABCD5678 from sp=0x7FF.
        step();
        drive(1'b1, 3'd5, '0, 32'hABCD_5678);
        #2;
        chk("push32_hi_wr",   32'(mem_write), 32'd1);
        chk("push32_hi_addr", 32'(mem_addr), 32'h7FF);
        chk("push32_hi_wd",   32'(mem_wd), 32'hABCD);
        chk("push32_stall",   32'(stall), 32'd1);
        step();
        #2;
        chk("push32_lo_wr",   32'(mem_write), 32'd1);
        chk("push32_lo_addr", 32'(mem_addr), 32'h7FE);
        chk("push32_lo_wd",   32'(mem_wd), 32'h5678);
        chk("push32_stall2",  32'(stall), 32'd0);

        // POP32 back.
        step();
        drive(1'b1, 3'd6, '0, 32'h0);
        exp_q.push_back(32'hABCD_5678);
        #2;
        chk("push32_sp", 32'(sp), 32'h7FD);
        chk("mem_7FF",   32'(mem[11'h7FF]), 32'hABCD);
        chk("mem_7FE",   32'(mem[11'h7FE]), 32'h5678);
        chk("pop32_rd1",    32'(mem_read), 32'd1);
        chk("pop32_addr1",  32'(mem_addr), 32'h7FE);
        chk("pop32_stall1", 32'(stall), 32'd1);
        step();
        #2;
        chk("pop32_rd2",    32'(mem_read), 32'd1);
        chk("pop32_addr2",  32'(mem_addr), 32'h7FF);
        chk("pop32_stall2", 32'(stall), 32'd1);
        step();
        #2;
        chk("pop32_resp_vld", 32'(resp_valid), 32'd1);
        chk("pop32_stall3",   32'(stall), 32'd0);
        chk("pop32_sp",       32'(sp), 32'h7FF);

        // POP at sp=0x7FF wraps to address 0x000.
        step();
        drive(1'b1, 3'd4, '0, 32'h0);
        exp_q.push_back(32'h0000_BEEF);
        #2;
        chk("pop_wrap_addr",  32'(mem_addr), 32'h000);
        chk("pop_wrap_rd",    32'(mem_read), 32'd1);
        chk("pop_wrap_stall", 32'(stall), 32'd1);
        step();
        #2;
        chk("pop_wrap_sp",  32'(sp), 32'h000);
        chk("pop_resp_vld", 32'(resp_valid), 32'd1);

        // PUSH at sp=0x000 wraps back to 0x7FF.
        step();
        drive(1'b1, 3'd3, '0, 32'h0000_0042);
        #2;
        chk("push_wr",    32'(mem_write), 32'd1);
        chk("push_addr",  32'(mem_addr), 32'h000);
        chk("push_wd",    32'(mem_wd), 32'h0042);
        chk("push_stall", 32'(stall), 32'd0);

        // NOP encodings: no access, sp unchanged.
        step();
        drive(1'b1, 3'd7, 11'h123, 32'hFFFF_FFFF);
        #2;
        chk("push_wrap_sp", 32'(sp), 32'h7FF);
        chk("nop7_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("nop7_stall",   32'(stall), 32'd0);
        step();
        drive(1'b1, 3'd0, 11'h123, 32'hFFFF_FFFF);
        #2;
        chk("nop0_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("nop0_sp",      32'(sp), 32'h7FF);

        // Reset during RD_HI of a POP32.
        step();
        drive(1'b1, 3'd6, '0, 32'h0);
        step();
        rst = 1'b1;
        #2;
        chk("rst_mid_rd",    32'(mem_read), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_resp",  32'(resp_valid), 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 3'd2, 11'h005, 32'h0000_7777);
        #2;
        chk("rst_after_sp",   32'(sp), 32'h7FF);
        chk("rst_after_resp", 32'(resp_valid), 32'd0);
        chk("rst_after_wr",   32'(mem_write), 32'd1);
        chk("rst_after_addr", 32'(mem_addr), 32'h005);
        step();
        drive(1'b0, 3'd0, '0, 32'h0);
        step();
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data memory word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 11, data memory address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present from EX/MEM register.
REQ-006 SHALL have port req_op  input  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH32, 6 POP32, 7 NOP.
REQ-007 SHALL have port req_addr  input  ADDR_SIZE  effective address for LOAD/STORE.
REQ-008 SHALL have port req_wdata  input  2*WORD_SIZE  store data; PUSH32 stores PC as {hi,lo}.
REQ-009 SHALL have port mem_read  output  1  read strobe to data memory.
REQ-010 SHALL have port mem_write  output  1  write strobe to data memory.
REQ-011 SHALL have port mem_addr  output  ADDR_SIZE  data memory address.
REQ-012 SHALL have port mem_wd  output  WORD_SIZE  data memory write data.
REQ-013 SHALL have port mem_rd  input  WORD_SIZE  data memory read data, valid the cycle after mem_read is sampled.
REQ-014 SHALL have port stall  output  1  freeze upstream stages and EX/MEM register.
REQ-015 SHALL have port resp_valid  output  1  read result valid this cycle.
REQ-016 SHALL have port resp_data  output  2*WORD_SIZE  read result to MEM/WB.
REQ-017 SHALL have port sp  output  ADDR_SIZE  current stack pointer.

Function
REQ-018 SHALL implement FSM states IDLE, WR_LO, RD_HI, RD_LAST; requests decoded only in IDLE; req inputs ignored in other states (upstream holds them while stall=1).
REQ-019 SHALL never assert mem_read and mem_write in the same cycle; mem strobes, stall, resp_valid are 0 whenever no access is due.
REQ-020 SHALL, in IDLE with STORE: mem_write=1, mem_addr=req_addr, mem_wd=req_wdata[15:0], stall=0, stay IDLE.
REQ-021 SHALL, in IDLE with PUSH: mem_write=1, mem_addr=sp, mem_wd=req_wdata[15:0], sp<=sp-1, stall=0.
REQ-022 SHALL, in IDLE with LOAD: mem_read=1, mem_addr=req_addr, stall=1, next RD_LAST.
REQ-023 SHALL, in IDLE with POP: mem_read=1, mem_addr=sp+1, sp<=sp+1, stall=1, next RD_LAST.
REQ-024 SHALL, in IDLE with PUSH32: mem_write=1, mem_addr=sp, mem_wd=req_wdata[31:16], stall=1, next WR_LO.
REQ-025 SHALL, in WR_LO: mem_write=1, mem_addr=sp-1, mem_wd=req_wdata[15:0], sp<=sp-2, stall=0, next IDLE.
REQ-026 SHALL, in IDLE with POP32: mem_read=1, mem_addr=sp+1, stall=1, next RD_HI.
REQ-027 SHALL, in RD_HI: latch mem_rd as low half, mem_read=1, mem_addr=sp+2, sp<=sp+2, stall=1, next RD_LAST.
REQ-028 SHALL, in RD_LAST: stall=0, resp_valid=1, resp_data={latched low, mem_rd} reversed as {mem_rd,latched low} for POP32, {16'h0,mem_rd} for LOAD/POP; next IDLE.
REQ-029 SHALL give latencies: STORE/PUSH 1 cycle, LOAD/POP/PUSH32 2 cycles, POP32 3 cycles.
REQ-030 SHALL do all sp and address arithmetic modulo 2**ADDR_SIZE (0x7FF+1 wraps to 0x000, 0x000-1 to 0x7FF); no overflow flag.
REQ-031 SHALL treat req_valid=0 or op 0/7 in IDLE as no access, sp unchanged.

Reset
REQ-032 SHALL on rst: state<=IDLE, sp<=2**ADDR_SIZE-1 (0x7FF), latched low half<=0.
REQ-033 SHALL force mem_read, mem_write, stall, resp_valid to 0 combinationally while rst=1, including mid-operation; aborted multi-cycle ops leave no further writes.

Structure
REQ-034 SHALL take op encodings, FSM state encoding and SP_RESET from shared package mem_stage_pkg.
REQ-035 SHALL instantiate one sub-module stack_pointer (register, reset value, +1/+2/-1/-2 update).

Verification
REQ-036 SHALL test reset: rst 1 cycle -> sp=0x7FF, all strobes 0, stall 0.
REQ-037 SHALL test STORE 0x00A,0x1234 then LOAD 0x00A -> write cycle, then stall 1 cycle, resp_data=0x00001234.
REQ-038 SHALL test PUSH32 0xABCD5678 then POP32 -> mem[0x7FF]=0xABCD, mem[0x7FE]=0x5678, sp 0x7FD then 0x7FF, resp_data=0xABCD5678 after 3 cycles.
REQ-039 SHALL test POP with sp=0x7FF -> read address 0x000, sp=0x000 (wrap).
REQ-040 SHALL test rst asserted in RD_HI of POP32 -> next cycle IDLE, sp=0x7FF, no resp_valid.
